// File: rtl/syscall_unit_if.sv
// Bus between the CPU datapath (register read ports, PC enable, display) and syscall_unit.
interface syscall_unit_if;
  logic        syscall;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        pc_en;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic [15:0] print_cnt;
  logic        halted;

  modport master (
    output syscall, v0, a0,
    input  pc_en, disp_data, disp_valid, print_cnt, halted
  );

  modport slave (
    input  syscall, v0, a0,
    output pc_en, disp_data, disp_valid, print_cnt, halted
  );
endinterface

// File: rtl/syscall_unit.sv
// Syscall responder: prints $a0 on PRINT_CODE, otherwise halts the PC until Go is pressed.
// Optional Go debounce filter enabled by defining SYSCALL_GO_DEBOUNCE_EN.
module syscall_unit #(
  parameter logic [31:0] PRINT_CODE      = 32'h0000_0022,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           go,
  syscall_unit_if.slave  bus
);

  typedef enum logic [1:0] {RUN, HALT, RESUME} state_e;

  generate
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES out of range 1..65535");
    end
  endgenerate

  state_e      state_q, state_d, eval_state;
  logic [31:0] disp_data_q, disp_data_d;
  logic        disp_valid_q, disp_valid_d;
  logic [15:0] print_cnt_q, print_cnt_d;
  logic        halted_q, halted_d;
  logic        go_s1_q, go_s2_q, go_prev_q;
  logic        go_lvl, go_pulse, pc_en;
  logic        is_print, is_halt;

`ifdef SYSCALL_GO_DEBOUNCE_EN
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  logic        go_filt_q, go_filt_d;
  logic [15:0] db_cnt_q, db_cnt_d;

  // Any return of the synchronized level to the filtered level restarts the count.
  always_comb begin
    go_filt_d = go_filt_q;
    db_cnt_d  = '0;
    if (go_s2_q != go_filt_q) begin
      if (db_cnt_q == DB_LAST) begin
        go_filt_d = go_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      go_filt_q <= 1'b0;
      db_cnt_q  <= '0;
    end else begin
      go_filt_q <= go_filt_d;
      db_cnt_q  <= db_cnt_d;
    end
  end

  assign go_lvl = go_filt_q;
`else
  assign go_lvl = go_s2_q;
`endif

  assign go_pulse = go_lvl & ~go_prev_q;
  assign is_print = bus.syscall && (bus.v0 == PRINT_CODE);
  assign is_halt  = bus.syscall && (bus.v0 != PRINT_CODE);

  // pc_en follows the RUN equation while reset is asserted, whatever the state.
  assign eval_state = rst_n ? state_q : RUN;

  always_comb begin
    state_d      = state_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    print_cnt_d  = print_cnt_q;
    pc_en        = 1'b1;
    unique case (eval_state)
      RUN: begin
        pc_en = ~is_halt;
        if (is_print) begin
          disp_data_d  = bus.a0;
          disp_valid_d = 1'b1;
          print_cnt_d  = print_cnt_q + 16'd1;
        end
        if (is_halt) state_d = HALT;
      end
      HALT: begin
        pc_en = 1'b0;
        if (go_pulse) state_d = RESUME;
      end
      RESUME: begin
        pc_en   = 1'b1;
        state_d = RUN;
      end
      default: begin
        pc_en   = 1'b1;
        state_d = RUN;
      end
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      print_cnt_q  <= '0;
      halted_q     <= 1'b0;
      go_s1_q      <= 1'b0;
      go_s2_q      <= 1'b0;
      go_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      print_cnt_q  <= print_cnt_d;
      halted_q     <= halted_d;
      go_s1_q      <= go;
      go_s2_q      <= go_s1_q;
      go_prev_q    <= go_lvl;
    end
  end

  assign bus.pc_en      = pc_en;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.print_cnt  = print_cnt_q;
  assign bus.halted     = halted_q;

endmodule
